// File: rtl/nasti_addr_fifo.sv
// NASTI address-channel (AW/AR) FIFO: DEPTH-entry circular buffer with wrap-bit pointers.
// Optional macro NASTI_ADDR_FIFO_CROSS4K_EN tags INCR bursts that cross a 4 KiB boundary.
module nasti_addr_fifo #(
    parameter int ID_WIDTH   = 16,
    parameter int ADDR_WIDTH = 64,
    parameter int USER_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ID_WIDTH-1:0]   s_id,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [7:0]            s_len,
    input  logic [2:0]            s_size,
    input  logic [1:0]            s_burst,
    input  logic [3:0]            s_cache,
    input  logic [2:0]            s_prot,
    input  logic [3:0]            s_qos,
    input  logic [3:0]            s_region,
    input  logic [USER_WIDTH-1:0] s_user,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ID_WIDTH-1:0]   m_id,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [7:0]            m_len,
    output logic [2:0]            m_size,
    output logic [1:0]            m_burst,
    output logic [3:0]            m_cache,
    output logic [2:0]            m_prot,
    output logic [3:0]            m_qos,
    output logic [3:0]            m_region,
    output logic [USER_WIDTH-1:0] m_user,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  m_cross4k
);

    localparam int IDX_W = CNT_WIDTH - 1;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [USER_WIDTH-1:0] user;
`ifdef NASTI_ADDR_FIFO_CROSS4K_EN
        logic                  cross4k;
`endif
    } entry_t;

`ifdef NASTI_ADDR_FIFO_CROSS4K_EN
    // Last byte address is truncated to ADDR_WIDTH, so a wrap past the top also counts as a crossing.
    function automatic logic crosses_4k(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [7:0]            len,
                                        input logic [2:0]            size,
                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] last;
        last = addr + ({{(ADDR_WIDTH-8){1'b0}}, len} << size);
        return (burst == 2'b01) && (addr[ADDR_WIDTH-1:12] != last[ADDR_WIDTH-1:12]);
    endfunction
`endif

    entry_t                mem_q [DEPTH];
    entry_t                wr_entry_s;
    entry_t                head_s;
    logic [CNT_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  rstn_q;
    logic                  full_s, empty_s, push_s, pop_s;

    assign full_s  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                     (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign push_s  = s_valid & s_ready;
    assign pop_s   = m_valid & m_ready;

    // s_ready is a function of state only, so no path exists from m_ready.
    assign s_ready = rstn_q & ~full_s;
    assign m_valid = ~empty_s;
    assign count   = count_q;

    assign head_s   = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign m_id     = head_s.id;
    assign m_addr   = head_s.addr;
    assign m_len    = head_s.len;
    assign m_size   = head_s.size;
    assign m_burst  = head_s.burst;
    assign m_cache  = head_s.cache;
    assign m_prot   = head_s.prot;
    assign m_qos    = head_s.qos;
    assign m_region = head_s.region;
    assign m_user   = head_s.user;
`ifdef NASTI_ADDR_FIFO_CROSS4K_EN
    assign m_cross4k = ~empty_s & head_s.cross4k;
`else
    assign m_cross4k = 1'b0;
`endif

    // Pack the upstream request into one storage word.
    always_comb begin
        wr_entry_s        = '0;
        wr_entry_s.id     = s_id;
        wr_entry_s.addr   = s_addr;
        wr_entry_s.len    = s_len;
        wr_entry_s.size   = s_size;
        wr_entry_s.burst  = s_burst;
        wr_entry_s.cache  = s_cache;
        wr_entry_s.prot   = s_prot;
        wr_entry_s.qos    = s_qos;
        wr_entry_s.region = s_region;
        wr_entry_s.user   = s_user;
`ifdef NASTI_ADDR_FIFO_CROSS4K_EN
        wr_entry_s.cross4k = crosses_4k(s_addr, s_len, s_size, s_burst);
`endif
    end

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + CNT_WIDTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + CNT_WIDTH'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the FIFO asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstn_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rstn_q   <= 1'b1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are never read while the FIFO is empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_entry_s;
        end
    end

endmodule

// File: tb/tb_nasti_addr_fifo.sv
// Scoreboard bench for nasti_addr_fifo (default parameters, DEPTH=4).
module tb_nasti_addr_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] s_id;
    logic [63:0] s_addr;
    logic [7:0]  s_len;
    logic [2:0]  s_size;
    logic [1:0]  s_burst;
    logic [3:0]  s_cache;
    logic [2:0]  s_prot;
    logic [3:0]  s_qos;
    logic [3:0]  s_region;
    logic [7:0]  s_user;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_id;
    logic [63:0] m_addr;
    logic [7:0]  m_len;
    logic [2:0]  m_size;
    logic [1:0]  m_burst;
    logic [3:0]  m_cache;
    logic [2:0]  m_prot;
    logic [3:0]  m_qos;
    logic [3:0]  m_region;
    logic [7:0]  m_user;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  count;
    logic        m_cross4k;

`ifdef NASTI_ADDR_FIFO_CROSS4K_EN
    localparam logic X4K_ON = 1'b1;
`else
    localparam logic X4K_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] id;
        logic [63:0] addr;
        logic [35:0] attrs;
        logic        x4k;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    sb_entry_t exp_e;
    int        n_checks = 0;
    int        n_fail   = 0;
    int        n_pops   = 0;

    nasti_addr_fifo dut (
        .clk(clk), .rstn(rstn),
        .s_id(s_id), .s_addr(s_addr), .s_len(s_len), .s_size(s_size), .s_burst(s_burst),
        .s_cache(s_cache), .s_prot(s_prot), .s_qos(s_qos), .s_region(s_region), .s_user(s_user),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_id(m_id), .m_addr(m_addr), .m_len(m_len), .m_size(m_size), .m_burst(m_burst),
        .m_cache(m_cache), .m_prot(m_prot), .m_qos(m_qos), .m_region(m_region), .m_user(m_user),
        .m_valid(m_valid), .m_ready(m_ready),
        .count(count), .m_cross4k(m_cross4k)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_x4k(input logic [63:0] a, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [63:0] last;
        last = a + ({56'd0, len} << size);
        return X4K_ON && (burst == 2'b01) && (a[63:12] != last[63:12]);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        s_id     = id;
        s_addr   = addr;
        s_len    = len;
        s_size   = size;
        s_burst  = burst;
        s_cache  = 4'($urandom);
        s_prot   = 3'($urandom);
        s_qos    = 4'($urandom);
        s_region = 4'($urandom);
        s_user   = 8'($urandom);
    endtask

    task automatic drain;
        m_ready = 1'b1;
        s_valid = 1'b0;
        for (int k = 0; k < 40 && count != 3'd0; k++) tick;
        check_val("drain_count", 64'(count), 64'd0);
        check_val("drain_mvalid", 64'(m_valid), 64'd0);
    endtask

    // Scoreboard: capture requests on upstream handshake, compare on downstream handshake.
    always @(negedge clk) begin
        if (!rstn) begin
            sb_q.delete();
        end else begin
            if (m_valid && m_ready) begin
                check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    exp_e = sb_q.pop_front();
                    n_pops++;
                    check_val("pop_id", 64'(m_id), 64'(exp_e.id));
                    check_val("pop_addr", m_addr, exp_e.addr);
                    check_val("pop_attrs",
                              64'({m_len, m_size, m_burst, m_cache, m_prot, m_qos, m_region, m_user}),
                              64'(exp_e.attrs));
                    check_val("pop_x4k", 64'(m_cross4k), 64'(exp_e.x4k));
                end
            end
            if (s_valid && s_ready) begin
                exp_e.id    = s_id;
                exp_e.addr  = s_addr;
                exp_e.attrs = {s_len, s_size, s_burst, s_cache, s_prot, s_qos, s_region, s_user};
                exp_e.x4k   = model_x4k(s_addr, s_len, s_size, s_burst);
                sb_q.push_back(exp_e);
            end
        end
    end

    initial begin
        int pops0;
        rstn    = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        set_req(16'd0, 64'd0, 8'd0, 3'd0, 2'b01);
        #1;
        check_val("rst_sready", 64'(s_ready), 64'd0);
        check_val("rst_mvalid", 64'(m_valid), 64'd0);
        check_val("rst_count", 64'(count), 64'd0);
        check_val("rst_x4k", 64'(m_cross4k), 64'd0);
        tick;
        tick;
        rstn = 1'b1;
        check_val("rel_sready_low", 64'(s_ready), 64'd0);
        tick;
        check_val("rel_sready_high", 64'(s_ready), 64'd1);

        // Single request: one-cycle latency, then popped.
        set_req(16'd3, 64'h1000, 8'd0, 3'd2, 2'b01);
        s_valid = 1'b1;
        m_ready = 1'b1;
        check_val("t1_mvalid_pre", 64'(m_valid), 64'd0);
        tick;
        s_valid = 1'b0;
        check_val("t1_mvalid", 64'(m_valid), 64'd1);
        check_val("t1_count1", 64'(count), 64'd1);
        check_val("t1_id", 64'(m_id), 64'd3);
        check_val("t1_addr", m_addr, 64'h1000);
        tick;
        check_val("t1_count0", 64'(count), 64'd0);
        check_val("t1_empty", 64'(m_valid), 64'd0);

        // Fill to full, pop while full, refill, drain in order.
        m_ready = 1'b0;
        pops0 = n_pops;
        for (int i = 1; i <= 5; i++) begin
            set_req(16'(i), 64'(32'h2000 + 32'(i) * 32'h40), 8'(i), 3'd3, 2'b01);
            s_valid = 1'b1;
            check_val("fill_sready", 64'(s_ready), 64'(i <= 4));
            if (i <= 4) tick;
        end
        check_val("full_count", 64'(count), 64'd4);
        m_ready = 1'b1;
        check_val("full_pop_sready", 64'(s_ready), 64'd0);
        tick;
        check_val("after_pop_count", 64'(count), 64'd3);
        check_val("after_pop_sready", 64'(s_ready), 64'd1);
        m_ready = 1'b0;
        tick;
        check_val("refill_count", 64'(count), 64'd4);
        check_val("refill_sready", 64'(s_ready), 64'd0);
        drain;
        check_val("fill_pops", 64'(n_pops - pops0), 64'd5);

        // Streaming push+pop with wrap.
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_req(16'(16 + i), {$urandom, $urandom}, 8'($urandom), 3'($urandom), 2'($urandom));
            s_valid = 1'b1;
            tick;
            check_val("stream_count", 64'(count), 64'd1);
        end
        s_valid = 1'b0;
        tick;
        check_val("stream_end_count", 64'(count), 64'd0);

        // Asynchronous reset with three stored entries.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(16'(40 + i), 64'(i) << 12, 8'd1, 3'd2, 2'b01);
            s_valid = 1'b1;
            tick;
        end
        s_valid = 1'b0;
        check_val("pre_rst_count", 64'(count), 64'd3);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check_val("arst_mvalid", 64'(m_valid), 64'd0);
        check_val("arst_count", 64'(count), 64'd0);
        check_val("arst_sready", 64'(s_ready), 64'd0);
        tick;
        rstn = 1'b1;
        check_val("rel2_sready_low", 64'(s_ready), 64'd0);
        tick;
        check_val("rel2_sready_high", 64'(s_ready), 64'd1);
        check_val("rel2_mvalid", 64'(m_valid), 64'd0);

        // 4 KiB crossing tag.
        set_req(16'd60, 64'h0FF0, 8'd3, 3'd3, 2'b01);
        s_valid = 1'b1;
        tick;
        set_req(16'd61, 64'h0F00, 8'd3, 3'd3, 2'b01);
        tick;
        set_req(16'd62, 64'h0FF0, 8'd3, 3'd3, 2'b00);
        tick;
        s_valid = 1'b0;
        check_val("x4k_incr_cross", 64'(m_cross4k), 64'(X4K_ON));
        m_ready = 1'b1;
        tick;
        check_val("x4k_incr_inside", 64'(m_cross4k), 64'd0);
        tick;
        check_val("x4k_fixed", 64'(m_cross4k), 64'd0);
        drain;

        // Random traffic with back-pressure on both sides.
        for (int i = 0; i < 60; i++) begin
            set_req(16'($urandom), {$urandom, $urandom}, 8'($urandom), 3'($urandom), 2'($urandom));
            s_valid = 1'($urandom);
            m_ready = 1'($urandom);
            tick;
        end
        drain;
        check_val("sb_left", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nasti_addr_fifo.md
Name: nasti_addr_fifo

Overview:
- Parametrised buffer for one NASTI address channel (AW or AR); widths and depth are set per instance.
- Decouples a master-side address channel from a slave-side address channel and stores up to DEPTH requests.
- Sits between a NASTI master port and a crossbar or slave port, for timing isolation and request queuing.
- Reports current occupancy; an optional feature tags INCR bursts that cross a 4 KiB boundary.

Parameters:
- ID_WIDTH, 16: width of id field, 1..16.
- ADDR_WIDTH, 64: width of addr field, 13..64.
- USER_WIDTH, 8: width of user field, 1..8.
- DEPTH, 4: number of entries; power of two, >= 2.
- CNT_WIDTH, $clog2(DEPTH)+1: width of occupancy count (derived, do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- s_id  in  ID_WIDTH  upstream request id.
- s_addr  in  ADDR_WIDTH  upstream address.
- s_len  in  8  burst length minus one.
- s_size  in  3  log2 bytes per beat.
- s_burst  in  2  burst type.
- s_cache  in  4  cache attributes.
- s_prot  in  3  protection attributes.
- s_qos  in  4  QoS.
- s_region  in  4  region.
- s_user  in  USER_WIDTH  user sideband.
- s_valid  in  1  upstream valid.
- s_ready  out  1  upstream ready.
- m_id, m_addr, m_len, m_size, m_burst, m_cache, m_prot, m_qos, m_region, m_user  out  (same widths as s_*)  downstream request fields.
- m_valid  out  1  downstream valid.
- m_ready  in  1  downstream ready.
- count  out  CNT_WIDTH  number of stored entries, 0..DEPTH.
- m_cross4k  out  1  head entry crosses a 4 KiB boundary (feature only; tied 0 otherwise).

Behaviour:
- Clock and reset: single clock clk; reset rstn is asynchronous and active-low.
- Storage: circular array of DEPTH entries; write and read pointers are CNT_WIDTH bits wide, with the MSB used as the wrap bit.
- Full/empty: full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
- Reset state: pointers = 0, count = 0, s_ready = 0 while rstn is low, m_valid = 0, m_cross4k = 0. Entry contents are don't-care.
- s_ready = rstn_q & !full, where rstn_q is a register reset to 0 and set to 1 on the first clock edge after reset release. s_ready must not depend on m_ready (no combinational path).
- m_valid = !empty. m_* fields are driven from the entry at the read pointer.
- Push: s_valid & s_ready at a rising edge writes all s_* fields to the write-pointer entry and increments the write pointer.
- Pop: m_valid & m_ready at a rising edge increments the read pointer.
- Latency: a push into an empty FIFO gives m_valid = 1 on the following cycle. There is no same-cycle bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When full, a pop in the same cycle does not enable a push; s_ready stays 0 that cycle and rises the next cycle.
- count: registered; increments on push-only, decrements on pop-only, otherwise holds.
- Pointer wrap: the low pointer bits wrap DEPTH-1 -> 0 and the MSB toggles at the same time.
- Ordering: strictly first in, first out across all ids. No reordering.
- Stability: while m_valid & !m_ready, the m_* fields are held stable, as the NASTI handshake requires.
- Reset mid-operation: all stored entries are discarded immediately (asynchronously); m_valid falls without waiting for a clock edge.
- Upstream rule: s_* fields are sampled only on a handshake. Behaviour when s_valid deasserts without a handshake is the upstream's responsibility and is not checked here.

Optional Feature:
- Macro: NASTI_ADDR_FIFO_CROSS4K_EN.
- When defined: each entry carries one extra bit, computed at push time, set when all of the following hold:
  - s_burst == 2'b01 (INCR);
  - s_addr[ADDR_WIDTH-1:12] != last[ADDR_WIDTH-1:12], where last = s_addr + (s_len << s_size), computed in ADDR_WIDTH bits with truncation.
- The bit is presented on m_cross4k alongside the head entry. It is informational only and does not alter the handshake.
- When not defined: no extra storage bit; m_cross4k tied 0.

Test Plan:
- Reset then single push of id=3, addr=0x1000, len=0 with m_ready=1 -> m_valid rises one cycle after the push with m_id=3, m_addr=0x1000; count goes 0 -> 1 -> 0.
- DEPTH=4, m_ready=0, push 5 requests with ids 1..5 -> ids 1..4 accepted, s_ready=0 after the 4th, count=4. Raise m_ready -> ids pop in order 1,2,3,4, then id 5 is accepted and pops.
- Full FIFO with s_valid=1 and m_ready=1 in the same cycle -> pop occurs, no push that cycle, s_ready=1 next cycle, count 4 -> 3 -> 4.
- Continuous push/pop of 10 requests with both valid and ready high -> pointers wrap twice, count stays at 1, output order matches input order.
- rstn asserted low with count=3 -> m_valid and count drop to 0 asynchronously; after release, s_ready stays 0 for one cycle, then goes to 1.
- With NASTI_ADDR_FIFO_CROSS4K_EN defined:
  - burst=INCR, addr=0x0FF0, len=3, size=3 -> m_cross4k=1.
  - Same but addr=0x0F00 -> m_cross4k=0.
  - burst=FIXED, addr=0x0FF0 -> m_cross4k=0.
